// File: rtl/imem_pkg.sv
// Shared types for the instruction memory: FSM state encoding and the default NOP word.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } imem_state_e;

   localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/imem_array.sv
// Single-port DEPTH x XLEN synchronous RAM: one write or one registered read per cycle.
// Read data updates only on a read enable, so it holds while the fetch side stalls.
module imem_array #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 1024,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            we,
   input  logic            re,
   input  logic [AW-1:0]   addr,
   input  logic [XLEN-1:0] wdata,
   output logic [XLEN-1:0] rdata
);

   logic [XLEN-1:0] mem [DEPTH];
   logic [XLEN-1:0] rdata_q;
   logic [XLEN-1:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re && !we) begin
         rdata_d = mem[addr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/instr_mem_pipe.sv
// Instruction memory with post-reset clear, valid/ready program load and a 1-cycle registered fetch port.
// Stall holds the fetch outputs; loads stall fetches via busy. Fault detection under IMEM_FAULT_CHECK_EN.
module instr_mem_pipe
   import imem_pkg::*;
#(
   parameter int unsigned      XLEN  = 32,
   parameter int unsigned      DEPTH = 1024,
   parameter logic [XLEN-1:0]  NOP   = XLEN'(IMEM_NOP),
   localparam int unsigned     AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_req,
   input  logic [31:0]     fetch_addr,
   input  logic            stall,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic            fetch_fault,
   output logic            busy,
   input  logic            load_start,
   input  logic [AW-1:0]   load_base,
   input  logic            load_valid,
   input  logic [XLEN-1:0] load_data,
   input  logic            load_last,
   output logic            load_ready
);

   imem_state_e     state_q, state_d;
   logic [AW-1:0]   ptr_q, ptr_d;
   logic            valid_q, valid_d;
   logic            fault_q, fault_d;

   logic            fetch_acc;
   logic            addr_bad;
   logic [AW-1:0]   fetch_idx;
   logic            ram_we;
   logic            ram_re;
   logic [AW-1:0]   ram_addr;
   logic [XLEN-1:0] ram_wdata;
   logic [XLEN-1:0] ram_rdata;

   assign fetch_idx = fetch_addr[AW+1:2];
   assign fetch_acc = (state_q == ST_RUN) && fetch_req && !stall;

`ifdef IMEM_FAULT_CHECK_EN
   assign addr_bad = (|fetch_addr[1:0]) || (|fetch_addr[31:AW+2]);
`else
   logic unused_addr_bits;
   assign unused_addr_bits = ^{fetch_addr[31:AW+2], fetch_addr[1:0]};
   assign addr_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            ptr_d = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (load_start) begin
               state_d = ST_LOAD;
               ptr_d   = load_base;
            end
         end
         ST_LOAD: begin
            // Pointer wraps naturally at DEPTH since AW = log2(DEPTH).
            if (load_valid) begin
               ptr_d = ptr_q + AW'(1);
               if (load_last) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_comb begin
      busy       = (state_q != ST_RUN);
      load_ready = (state_q == ST_LOAD);
      ram_we     = !rst && ((state_q == ST_CLEAR) || ((state_q == ST_LOAD) && load_valid));
      ram_re     = !rst && fetch_acc && !addr_bad;
      ram_addr   = ram_we ? ptr_q : fetch_idx;
      ram_wdata  = (state_q == ST_CLEAR) ? NOP : load_data;
   end

   always_comb begin
      valid_d = valid_q;
      fault_d = fault_q;
      if (!stall) begin
         valid_d = fetch_acc;
         fault_d = fetch_acc && addr_bad;
      end
   end

   imem_array #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // RAM read register holds across stalls; NOP is substituted for idle and faulted fetches.
   assign instr       = (valid_q && !fault_q) ? ram_rdata : NOP;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;

endmodule

// File: doc/instr_mem_pipe.md
# instr_mem_pipe

Parametrised, synchronous-read instruction memory for the pipelined MIPS core, sitting between the fetch stage (PC register) and the IF/ID pipeline register. It replaces the fixed 1024×32 asynchronous array with a configurable-depth store that is cleared word-by-word after reset and loaded at run time through a valid/ready program-load port. It also adds a registered fetch port with stall support and optional address fault detection.

## Interface
Parameters:
- XLEN, 32, instruction width in bits.
- DEPTH, 1024, number of words; power of two, ≥ 4.
- NOP, 32'h0000_0000, word driven on `instr` when no valid instruction is present.
- AW, $clog2(DEPTH), word-index width (derived, not overridden).

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  fetch request for `fetch_addr`.
- fetch_addr  in  32  byte address (PC).
- stall  in  1  hold `instr`/`instr_valid` unchanged.
- instr  out  XLEN  fetched instruction.
- instr_valid  out  1  `instr` holds a real fetched word.
- fetch_fault  out  1  the last accepted fetch was misaligned or out of range.
- busy  out  1  in CLEAR or LOAD; fetches are not accepted.
- load_start  in  1  single-cycle pulse that opens a load burst.
- load_base  in  AW  first word index of the burst.
- load_valid  in  1  load beat present.
- load_data  in  XLEN  load beat word.
- load_last  in  1  marks the final beat of the burst.
- load_ready  out  1  block accepts load beats.

## Operation
- FSM states: CLEAR, RUN, LOAD.
  - rst → CLEAR with ptr=0.
  - CLEAR writes NOP to mem[ptr] and increments ptr each cycle; after writing word DEPTH-1 it moves to RUN.
  - RUN + load_start → LOAD, ptr=load_base. load_start is ignored in CLEAR and LOAD.
  - LOAD: each beat with load_valid&&load_ready writes load_data to mem[ptr], then ptr=(ptr+1) mod DEPTH. A beat with load_last also moves the FSM to RUN.
- load_ready=1 only in LOAD. busy=1 in CLEAR and LOAD.
- Word index = fetch_addr[AW+1:2].
- Fetch accepted when state==RUN && fetch_req && !stall. The next cycle gives instr=mem[index], instr_valid=1.
- When !stall and no fetch is accepted, the next cycle gives instr=NOP, instr_valid=0, fetch_fault=0.
- When stall=1, instr, instr_valid and fetch_fault hold in every state, including across FSM transitions. Only rst overrides stall.
- A fetch is never accepted in the same cycle as a load write, so there is no read/write collision. A fetch in the same cycle as load_start is served normally.
- Reset mid-CLEAR or mid-LOAD aborts the operation and restarts CLEAR from word 0. Partially loaded words are overwritten.

## Timing
- Reset values: instr=NOP, instr_valid=0, fetch_fault=0, busy=1, load_ready=0.
- CLEAR lasts exactly DEPTH cycles after rst deasserts. busy falls on cycle DEPTH+1.
- Fetch latency is 1 cycle, with registered outputs. Back-to-back fetches give one instruction per cycle.
- LOAD entered the cycle after load_start, so load_ready rises 1 cycle after the pulse. busy falls the cycle after the load_last beat.
- Burst writes wrap from DEPTH-1 to 0 with no error.

## Configuration
- IMEM_FAULT_CHECK_EN defined:
  - An accepted fetch with fetch_addr[1:0]≠0, or with fetch_addr ≥ 4·DEPTH, returns instr=NOP, instr_valid=1, fetch_fault=1.
- IMEM_FAULT_CHECK_EN undefined:
  - fetch_fault is tied 0.
  - Low address bits and bits above AW+1 are ignored, so the address wraps modulo DEPTH.

## Structure
- The shared imem_pkg holds the FSM state enum (CLEAR/RUN/LOAD) and the default NOP constant.
- One sub-module, imem_array: a single-port synchronous DEPTH×XLEN RAM with one write port and one registered read port. The FSM and fetch logic sit in the top level.

## Test plan
- Reset clear: preload nonzero words, assert rst 1 cycle → busy=1 for exactly 1024 cycles. Fetch of 0x0 then returns 32'h0, instr_valid=1.
- Load and fetch: load_start with load_base=2, beats 0x014A5020, 0x8C0A0020, 0x114A0003 (last) → busy falls 1 cycle after the last beat. Fetches of 0x8, 0xC, 0x10 return those words on consecutive cycles.
- Stall: fetch 0x8, then stall=1 for 3 cycles while fetch_addr changes → instr stays 0x014A5020 with valid=1. Release stall → the new address is served 1 cycle later.
- Wrap: load_base=1023, beats 0xAAAA0001, 0xAAAA0002 (last) → word 1023=0xAAAA0001, word 0=0xAAAA0002.
- Fault (IMEM_FAULT_CHECK_EN): fetch 0x6 and fetch 0x1000 → instr=NOP, fetch_fault=1 for each. Without the macro, 0x1000 returns word 0.
- Reset mid-load: rst after 1 of 3 beats → load_ready=0 next cycle, CLEAR restarts, and word base reads 0 afterwards.
